// File: rtl/k2_fetch_decode_if.sv
// K2 fetch/decode bundle: PC link, program-load port, run control and decoded datapath controls.
// master = surrounding core/loader side, slave = k2_fetch_decode.
interface k2_fetch_decode_if #(
    parameter int N          = 8,
    parameter int INSTR_BITS = 4
);
    logic [INSTR_BITS-1:0] counter;
    logic                  prog_we;
    logic [INSTR_BITS-1:0] prog_addr;
    logic [7:0]            prog_data;
    logic                  run_start;
    logic                  alu_carry;
    logic                  jump;
    logic [2:0]            jump_imm;
    logic                  load_a;
    logic                  load_b;
    logic                  load_out;
    logic                  sel_imm;
    logic                  alu_sub;
    logic [N-1:0]          imm;
    logic                  running;
    logic                  carry_flag;

    modport master (
        output counter, prog_we, prog_addr, prog_data, run_start, alu_carry,
        input  jump, jump_imm, load_a, load_b, load_out, sel_imm, alu_sub, imm,
               running, carry_flag
    );

    modport slave (
        input  counter, prog_we, prog_addr, prog_data, run_start, alu_carry,
        output jump, jump_imm, load_a, load_b, load_out, sel_imm, alu_sub, imm,
               running, carry_flag
    );
endinterface

// File: rtl/k2_fetch_decode.sv
// K2 fetch/decode stage: program store, instruction register, LOAD/START/RUN sequencer, decoder.
// Optional feature macro: K2_COND_JUMP_EN (JC honoured, carry flag register present).
module k2_fetch_decode #(
    parameter int N            = 8,
    parameter int INSTRUCTIONS = 9,
    parameter int INSTR_BITS   = $clog2(INSTRUCTIONS)
) (
    input logic              clk,
    input logic              reset,
    k2_fetch_decode_if.slave bus
);
    localparam logic [7:0]            NOP   = 8'h00;
    localparam logic [INSTR_BITS:0]   DEPTH = (INSTR_BITS + 1)'(INSTRUCTIONS);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [7:0]   store_r [INSTRUCTIONS];
    logic [7:0]   ir_r;
    logic [7:0]   fetch_s;
    logic         wr_ok_s;
    logic         rd_ok_s;
    logic         cond_ok_s;
    logic         alu_op_s;
    logic         jump_s;
    logic [2:0]   jump_imm_s;
    logic         load_a_s;
    logic         load_b_s;
    logic         load_out_s;
    logic         sel_imm_s;
    logic         alu_sub_s;
    logic [N-1:0] imm_s;

    assign wr_ok_s = ({1'b0, bus.prog_addr} < DEPTH);
    assign rd_ok_s = ({1'b0, bus.counter} < DEPTH);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: LOAD waits for run_start, START lasts one cycle, RUN is left only by reset.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (bus.run_start) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_START: state_s = ST_RUN;
            ST_RUN:   state_s = ST_RUN;
            default:  state_s = ST_LOAD;
        endcase
    end

    // Program store: cleared by reset, writable only while loading.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < INSTRUCTIONS; i++) begin
                store_r[i] <= NOP;
            end
        end else if ((state_r == ST_LOAD) && bus.prog_we && wr_ok_s) begin
            store_r[bus.prog_addr] <= bus.prog_data;
        end else begin
            store_r <= store_r;
        end
    end

    // Fetch select: a taken jump squashes the wrong-path word already addressed by the PC.
    always_comb begin
        fetch_s = NOP;
        if ((state_r == ST_RUN) && !jump_s && rd_ok_s) begin
            fetch_s = store_r[bus.counter];
        end else begin
            fetch_s = NOP;
        end
    end

    // Instruction register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ir_r <= NOP;
        end else begin
            ir_r <= fetch_s;
        end
    end

    // Decoder: everything is quiet outside RUN except the START jump to address 0.
    always_comb begin
        jump_s     = 1'b0;
        jump_imm_s = 3'd0;
        load_a_s   = 1'b0;
        load_b_s   = 1'b0;
        load_out_s = 1'b0;
        sel_imm_s  = 1'b0;
        alu_sub_s  = 1'b0;
        imm_s      = {N{1'b0}};
        alu_op_s   = 1'b0;
        if (state_r == ST_RUN) begin
            case (ir_r[7:6])
                2'b11: begin
                    if ((ir_r[4:3] == 2'b00) && cond_ok_s) begin
                        jump_s     = 1'b1;
                        jump_imm_s = ir_r[2:0];
                    end else begin
                        jump_s     = 1'b0;
                    end
                end
                2'b10: begin
                    if (ir_r[4] == 1'b0) begin
                        load_a_s  = ~ir_r[5];
                        load_b_s  = ir_r[5];
                        sel_imm_s = 1'b1;
                        imm_s     = {{(N - 4){1'b0}}, ir_r[3:0]};
                    end else begin
                        sel_imm_s = 1'b0;
                    end
                end
                2'b01: begin
                    if (ir_r[3:0] == 4'h0) begin
                        load_a_s  = ~ir_r[5];
                        load_b_s  = ir_r[5];
                        alu_sub_s = ir_r[4];
                        alu_op_s  = 1'b1;
                    end else begin
                        alu_op_s  = 1'b0;
                    end
                end
                default: begin
                    load_out_s = (ir_r == 8'h20);
                end
            endcase
        end else if (state_r == ST_START) begin
            jump_s     = 1'b1;
            jump_imm_s = 3'd0;
        end else begin
            jump_s     = 1'b0;
        end
    end

`ifdef K2_COND_JUMP_EN
    logic carry_r;

    // Carry flag: captured at the end of every ADD/SUB so a following JC sees it directly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            carry_r <= 1'b0;
        end else if (alu_op_s) begin
            carry_r <= bus.alu_carry;
        end else begin
            carry_r <= carry_r;
        end
    end

    assign cond_ok_s      = ~ir_r[5] | carry_r;
    assign bus.carry_flag = carry_r;
`else
    logic [1:0] unused_s;

    assign unused_s       = {bus.alu_carry, alu_op_s};
    assign cond_ok_s      = 1'b1;
    assign bus.carry_flag = 1'b0;
`endif

    assign bus.jump     = jump_s;
    assign bus.jump_imm = jump_imm_s;
    assign bus.load_a   = load_a_s;
    assign bus.load_b   = load_b_s;
    assign bus.load_out = load_out_s;
    assign bus.sel_imm  = sel_imm_s;
    assign bus.alu_sub  = alu_sub_s;
    assign bus.imm      = imm_s;
    assign bus.running  = (state_r == ST_RUN);
endmodule

// File: tb/tb_k2_fetch_decode.sv
// Directed bench for k2_fetch_decode with a PC loopback model and an expected-result queue.
// Builds with or without K2_COND_JUMP_EN; expected sequences follow the macro.
module tb_k2_fetch_decode;
    logic clk;
    logic reset;
    bit   pc_loop;
    int   vectors;
    int   miscompares;
    logic [18:0] sb [$];

    k2_fetch_decode_if #(.N(8), .INSTR_BITS(4)) bus ();

    k2_fetch_decode #(.N(8), .INSTRUCTIONS(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {running, jump, jump_imm, load_a, load_b, load_out, sel_imm, alu_sub, imm, carry_flag}
    function automatic logic [18:0] pack(input logic run, input logic j, input logic [2:0] ji,
                                         input logic la, input logic lb, input logic lo,
                                         input logic si, input logic as, input logic [7:0] im,
                                         input logic cf);
        return {run, j, ji, la, lb, lo, si, as, im, cf};
    endfunction

    function automatic logic cfx(input logic x);
`ifdef K2_COND_JUMP_EN
        return x;
`else
        return 1'b0 & x;
`endif
    endfunction

    function automatic logic [18:0] e_nop(input logic run, input logic cf);
        return pack(run, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, cf);
    endfunction
    function automatic logic [18:0] e_start();
        return pack(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endfunction
    function automatic logic [18:0] e_jmp(input logic [2:0] t, input logic cf);
        return pack(1'b1, 1'b1, t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, cf);
    endfunction
    function automatic logic [18:0] e_ldi(input logic d, input logic [3:0] i, input logic cf);
        return pack(1'b1, 1'b0, 3'd0, ~d, d, 1'b0, 1'b1, 1'b0, {4'h0, i}, cf);
    endfunction
    function automatic logic [18:0] e_alu(input logic d, input logic s, input logic cf);
        return pack(1'b1, 1'b0, 3'd0, ~d, d, 1'b0, 1'b0, s, 8'h00, cf);
    endfunction
    function automatic logic [18:0] e_out(input logic cf);
        return pack(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, cf);
    endfunction

    // One clock: PC loopback model advances with the DUT, then the queued result is checked.
    task automatic step(input string tag, input logic [18:0] expv);
        logic [3:0]  nxt;
        logic [18:0] obs;
        logic [18:0] want;
        sb.push_back(expv);
        if (!reset)           nxt = 4'd0;
        else if (bus.jump)    nxt = {1'b0, bus.jump_imm};
        else if (bus.running) nxt = bus.counter + 4'd1;
        else                  nxt = 4'd0;
        @(posedge clk);
        #1;
        if (pc_loop) bus.counter = nxt;
        #1;
        obs  = pack(bus.running, bus.jump, bus.jump_imm, bus.load_a, bus.load_b, bus.load_out,
                    bus.sel_imm, bus.alu_sub, bus.imm, bus.carry_flag);
        want = sb.pop_front();
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] d, input logic go);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        bus.run_start = go;
        if (go) step("start", e_start());
        else    step("load", e_nop(1'b0, 1'b0));
        bus.prog_we   = 1'b0;
        bus.run_start = 1'b0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        pc_loop       = 1'b1;
        reset         = 1'b0;
        bus.counter   = 4'd0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = 4'd0;
        bus.prog_data = 8'h00;
        bus.run_start = 1'b0;
        bus.alu_carry = 1'b0;

        step("reset", e_nop(1'b0, 1'b0));
        reset = 1'b1;
        step("idle", e_nop(1'b0, 1'b0));

        // Program 1: basic decode, out-of-range write, write together with run_start.
        load_word(4'd0, 8'h85, 1'b0);
        load_word(4'd1, 8'hA3, 1'b0);
        load_word(4'd2, 8'h40, 1'b0);
        load_word(4'd3, 8'h20, 1'b0);
        load_word(4'd12, 8'hC1, 1'b0);
        load_word(4'd4, 8'hC4, 1'b1);
        step("bubble0", e_nop(1'b1, 1'b0));
        step("ldi_a5", e_ldi(1'b0, 4'd5, 1'b0));
        step("ldi_b3", e_ldi(1'b1, 4'd3, 1'b0));
        step("add_a", e_alu(1'b0, 1'b0, 1'b0));
        step("out", e_out(1'b0));
        step("jmp4", e_jmp(3'd4, 1'b0));
        step("jmp4_bub", e_nop(1'b1, 1'b0));
        step("jmp4_again", e_jmp(3'd4, 1'b0));

        // Reset with a JMP in IR, then run the cleared store.
        reset = 1'b0;
        step("rst_run", e_nop(1'b0, 1'b0));
        reset = 1'b1;
        step("rst_idle", e_nop(1'b0, 1'b0));
        bus.run_start = 1'b1;
        step("start_clr", e_start());
        bus.run_start = 1'b0;
        for (int i = 0; i < 4; i++) step("clr_store", e_nop(1'b1, 1'b0));

        // Program 2: taken JMP bubbles, RUN ignores prog_we/run_start.
        reset = 1'b0;
        step("rst2", e_nop(1'b0, 1'b0));
        reset = 1'b1;
        load_word(4'd0, 8'h85, 1'b0);
        load_word(4'd1, 8'hA3, 1'b0);
        load_word(4'd2, 8'hC5, 1'b0);
        load_word(4'd3, 8'h20, 1'b0);
        load_word(4'd4, 8'h00, 1'b0);
        load_word(4'd5, 8'hA7, 1'b0);
        load_word(4'd6, 8'hC0, 1'b1);
        step("bubble0", e_nop(1'b1, 1'b0));
        step("ldi_a5", e_ldi(1'b0, 4'd5, 1'b0));
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = 8'hFF;
        bus.run_start = 1'b1;
        step("ldi_b3", e_ldi(1'b1, 4'd3, 1'b0));
        step("jmp5", e_jmp(3'd5, 1'b0));
        step("jmp5_bub", e_nop(1'b1, 1'b0));
        step("ldi_b7", e_ldi(1'b1, 4'd7, 1'b0));
        step("jmp0", e_jmp(3'd0, 1'b0));
        bus.prog_we   = 1'b0;
        bus.run_start = 1'b0;
        step("jmp0_bub", e_nop(1'b1, 1'b0));
        step("store0_kept", e_ldi(1'b0, 4'd5, 1'b0));
        step("ldi_b3_again", e_ldi(1'b1, 4'd3, 1'b0));
        step("jmp5_again", e_jmp(3'd5, 1'b0));

        // Program 3: carry flag and conditional jump.
        reset = 1'b0;
        step("rst3", e_nop(1'b0, 1'b0));
        reset = 1'b1;
        load_word(4'd0, 8'h40, 1'b0);
        load_word(4'd1, 8'hE3, 1'b0);
        load_word(4'd2, 8'h20, 1'b0);
        load_word(4'd3, 8'h50, 1'b0);
        load_word(4'd4, 8'hE0, 1'b0);
        load_word(4'd5, 8'h20, 1'b0);
        load_word(4'd6, 8'hC6, 1'b1);
        step("bubble0", e_nop(1'b1, 1'b0));
        step("add_a", e_alu(1'b0, 1'b0, 1'b0));
        bus.alu_carry = 1'b1;
        step("jc3_taken", e_jmp(3'd3, cfx(1'b1)));
        bus.alu_carry = 1'b0;
        step("jc3_bub", e_nop(1'b1, cfx(1'b1)));
        step("sub_a", e_alu(1'b0, 1'b1, cfx(1'b1)));
`ifdef K2_COND_JUMP_EN
        step("jc0_not_taken", e_nop(1'b1, 1'b0));
        bus.alu_carry = 1'b1;
        step("out_no_bubble", e_out(1'b0));
        step("jmp6", e_jmp(3'd6, 1'b0));
        bus.alu_carry = 1'b0;
        step("jmp6_bub", e_nop(1'b1, 1'b0));
        step("jmp6_again", e_jmp(3'd6, 1'b0));
`else
        step("jc0_taken", e_jmp(3'd0, 1'b0));
        step("jc0_bub", e_nop(1'b1, 1'b0));
        bus.alu_carry = 1'b1;
        step("add_a_again", e_alu(1'b0, 1'b0, 1'b0));
        step("jc3_taken2", e_jmp(3'd3, 1'b0));
        bus.alu_carry = 1'b0;
`endif

        // Out-of-range PC values fetch NOP.
        pc_loop = 1'b0;
        for (int i = 9; i < 16; i++) begin
            bus.counter = 4'(i);
            step("pc_oob", e_nop(1'b1, 1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
